// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with fill level, almost-full/empty thresholds, sticky
// overflow/underflow, synchronous flush and optional first-word-fall-through read.
module sync_fifo_flags #(
  parameter int DATASIZE        = 8,
  parameter int ADDRSIZE        = 4,
  parameter int ALMOST_FULL_TH  = 14,
  parameter int ALMOST_EMPTY_TH = 2,
  parameter int FWFT            = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush,
  input  logic                write_enable,
  input  logic [DATASIZE-1:0] write_data,
  input  logic                read_enable,
  output logic [DATASIZE-1:0] read_data,
  output logic                write_full,
  output logic                read_empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [ADDRSIZE:0]   fill_count,
  output logic                overflow,
  output logic                underflow
);

  localparam int DEPTH = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE:0] DEPTH_C = (ADDRSIZE+1)'(DEPTH);
  localparam logic [ADDRSIZE:0] ONE_C   = (ADDRSIZE+1)'(1);
  localparam logic [ADDRSIZE:0] AF_TH   = (ADDRSIZE+1)'(ALMOST_FULL_TH);
  localparam logic [ADDRSIZE:0] AE_TH   = (ADDRSIZE+1)'(ALMOST_EMPTY_TH);

  logic [DATASIZE-1:0] mem_q [DEPTH];
  logic [ADDRSIZE:0]   wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  logic                ovf_q, ovf_d, unf_q, unf_d;
  logic                wr_acc, rd_acc;
  logic [ADDRSIZE-1:0] waddr, raddr;

  assign waddr = wptr_q[ADDRSIZE-1:0];
  assign raddr = rptr_q[ADDRSIZE-1:0];

  // Status is decoded from registered count only, never from the enables.
  assign fill_count   = count_q;
  assign write_full   = (count_q == DEPTH_C);
  assign read_empty   = (count_q == '0);
  assign almost_full  = (count_q >= AF_TH);
  assign almost_empty = (count_q <= AE_TH);
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  assign wr_acc = write_enable & ~write_full & ~flush;
  assign rd_acc = read_enable & ~read_empty & ~flush;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + ONE_C;
      if (rd_acc) rptr_d = rptr_q + ONE_C;
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase
      ovf_d = ovf_q | (write_enable & write_full);
      unf_d = unf_q | (read_enable & read_empty);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage has no reset; contents are only meaningful between pointers.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[waddr] <= write_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign read_data = mem_q[raddr];
    end else begin : g_reg
      logic [DATASIZE-1:0] rdata_q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    rdata_q <= '0;
        else if (rd_acc) rdata_q <= mem_q[raddr];
      end
      assign read_data = rdata_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: registered-read instance (u_dut0)
// and first-word-fall-through instance (u_dut1) sharing clock and reset.
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       fl0, we0, re0, fl1, we1, re1;
  logic [7:0] wd0, wd1, rd0, rd1;
  logic       full0, empty0, af0, ae0, ovf0, unf0;
  logic       full1, empty1, af1, ae1, ovf1, unf1;
  logic [4:0] cnt0, cnt1;
  int         n_run  = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  sync_fifo_flags #(.DATASIZE(8), .ADDRSIZE(4), .ALMOST_FULL_TH(14),
                    .ALMOST_EMPTY_TH(2), .FWFT(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .flush(fl0), .write_enable(we0),
    .write_data(wd0), .read_enable(re0), .read_data(rd0),
    .write_full(full0), .read_empty(empty0), .almost_full(af0),
    .almost_empty(ae0), .fill_count(cnt0), .overflow(ovf0), .underflow(unf0));

  sync_fifo_flags #(.DATASIZE(8), .ADDRSIZE(4), .ALMOST_FULL_TH(14),
                    .ALMOST_EMPTY_TH(2), .FWFT(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .flush(fl1), .write_enable(we1),
    .write_data(wd1), .read_enable(re1), .read_data(rd1),
    .write_full(full1), .read_empty(empty1), .almost_full(af1),
    .almost_empty(ae1), .fill_count(cnt1), .overflow(ovf1), .underflow(unf1));

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fl0 = 0; we0 = 0; re0 = 0; wd0 = '0;
    fl1 = 0; we1 = 0; re1 = 0; wd1 = '0;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    n_run++; if (cnt0 !== 5'd0) begin n_fail++; $display("FAIL rst_count got=%0d exp=0", cnt0); end
    n_run++; if ({empty0, ae0, full0, af0, ovf0, unf0} !== 6'b110000) begin n_fail++;
      $display("FAIL rst_flags got=%b exp=110000", {empty0, ae0, full0, af0, ovf0, unf0}); end
    n_run++; if (rd0 !== 8'h00) begin n_fail++; $display("FAIL rst_rdata got=%h exp=00", rd0); end
    n_run++; if ({empty1, cnt1} !== {1'b1, 5'd0}) begin n_fail++;
      $display("FAIL rst_fwft got=%b/%0d exp=1/0", empty1, cnt1); end
    // Asynchronous reset in the middle of traffic drops contents at once.
    for (int i = 0; i < 3; i++) begin we0 = 1; wd0 = 8'(i); tick(); end
    we0 = 0;
    reset_n = 1'b0;
    #1;
    n_run++; if ({cnt0, empty0} !== {5'd0, 1'b1}) begin n_fail++;
      $display("FAIL rst_async got=%0d/%b exp=0/1", cnt0, empty0); end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      we0 = 1; wd0 = 8'(i);
      tick();
      n_run++; if (cnt0 !== 5'(i + 1)) begin n_fail++; $display("FAIL fill_count got=%0d exp=%0d", cnt0, i + 1); end
      n_run++; if ({ae0, af0, full0} !== {(i + 1 <= 2), (i + 1 >= 14), (i + 1 == 16)}) begin n_fail++;
        $display("FAIL fill_flags n=%0d got=%b exp=%b", i + 1, {ae0, af0, full0},
                 {(i + 1 <= 2), (i + 1 >= 14), (i + 1 == 16)}); end
    end
    wd0 = 8'hAA;
    tick();
    we0 = 0;
    n_run++; if ({cnt0, ovf0, full0} !== {5'd16, 1'b1, 1'b1}) begin n_fail++;
      $display("FAIL fill_overflow got=%0d/%b/%b exp=16/1/1", cnt0, ovf0, full0); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      re0 = 1;
      tick();
      n_run++; if (rd0 !== 8'(i)) begin n_fail++; $display("FAIL drain_data got=%h exp=%h", rd0, 8'(i)); end
      n_run++; if (cnt0 !== 5'(15 - i)) begin n_fail++; $display("FAIL drain_count got=%0d exp=%0d", cnt0, 15 - i); end
    end
    n_run++; if ({empty0, unf0} !== 2'b10) begin n_fail++; $display("FAIL drain_empty got=%b exp=10", {empty0, unf0}); end
    tick();
    re0 = 0;
    n_run++; if ({unf0, rd0} !== {1'b1, 8'h0F}) begin n_fail++;
      $display("FAIL drain_underflow got=%b/%h exp=1/0f", unf0, rd0); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 8; i++) begin we0 = 1; wd0 = 8'(i); tick(); end
    for (int i = 0; i < 40; i++) begin
      we0 = 1; re0 = 1; wd0 = 8'(i + 8);
      tick();
      n_run++; if (rd0 !== 8'(i)) begin n_fail++; $display("FAIL b2b_data i=%0d got=%h exp=%h", i, rd0, 8'(i)); end
      n_run++; if (cnt0 !== 5'd8) begin n_fail++; $display("FAIL b2b_count got=%0d exp=8", cnt0); end
    end
    idle();
    n_run++; if ({ovf0, unf0} !== 2'b00) begin n_fail++; $display("FAIL b2b_sticky got=%b exp=00", {ovf0, unf0}); end
  endtask

  task automatic test_full_empty_rw();
    do_reset();
    for (int i = 0; i < 16; i++) begin we0 = 1; wd0 = 8'(8'h40 + i); tick(); end
    we0 = 1; re0 = 1; wd0 = 8'hEE;
    tick();
    idle();
    n_run++; if ({cnt0, ovf0, full0} !== {5'd15, 1'b1, 1'b0}) begin n_fail++;
      $display("FAIL fullrw got=%0d/%b/%b exp=15/1/0", cnt0, ovf0, full0); end
    n_run++; if (rd0 !== 8'h40) begin n_fail++; $display("FAIL fullrw_data got=%h exp=40", rd0); end
    fl0 = 1;
    tick();
    fl0 = 0;
    n_run++; if ({cnt0, ovf0, rd0} !== {5'd0, 1'b0, 8'h40}) begin n_fail++;
      $display("FAIL flush_hold got=%0d/%b/%h exp=0/0/40", cnt0, ovf0, rd0); end
    we0 = 1; re0 = 1; wd0 = 8'h77;
    tick();
    idle();
    n_run++; if ({cnt0, unf0, empty0} !== {5'd1, 1'b1, 1'b0}) begin n_fail++;
      $display("FAIL emptyrw got=%0d/%b/%b exp=1/1/0", cnt0, unf0, empty0); end
    n_run++; if (rd0 !== 8'h40) begin n_fail++; $display("FAIL emptyrw_data got=%h exp=40", rd0); end
    re0 = 1;
    tick();
    re0 = 0;
    n_run++; if (rd0 !== 8'h77) begin n_fail++; $display("FAIL emptyrw_pop got=%h exp=77", rd0); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 17; i++) begin we0 = 1; wd0 = 8'(i); tick(); end
    we0 = 0;
    for (int i = 0; i < 6; i++) begin re0 = 1; tick(); end
    re0 = 0;
    n_run++; if ({cnt0, ovf0} !== {5'd10, 1'b1}) begin n_fail++;
      $display("FAIL flush_pre got=%0d/%b exp=10/1", cnt0, ovf0); end
    fl0 = 1; we0 = 1; wd0 = 8'hC3;
    tick();
    idle();
    n_run++; if ({cnt0, empty0, ae0, full0, af0, ovf0, unf0} !== {5'd0, 6'b110000}) begin n_fail++;
      $display("FAIL flush_state got=%0d/%b exp=0/110000", cnt0, {empty0, ae0, full0, af0, ovf0, unf0}); end
    tick();
    n_run++; if (cnt0 !== 5'd0) begin n_fail++; $display("FAIL flush_drop got=%0d exp=0", cnt0); end
  endtask

  task automatic test_fwft();
    we1 = 1; wd1 = 8'h5A;
    tick();
    we1 = 0;
    n_run++; if ({empty1, cnt1} !== {1'b0, 5'd1}) begin n_fail++;
      $display("FAIL fwft_empty got=%b/%0d exp=0/1", empty1, cnt1); end
    n_run++; if (rd1 !== 8'h5A) begin n_fail++; $display("FAIL fwft_data got=%h exp=5a", rd1); end
    we1 = 1; wd1 = 8'h33;
    tick();
    we1 = 0;
    n_run++; if ({rd1, cnt1} !== {8'h5A, 5'd2}) begin n_fail++;
      $display("FAIL fwft_head got=%h/%0d exp=5a/2", rd1, cnt1); end
    re1 = 1;
    tick();
    re1 = 0;
    n_run++; if ({rd1, cnt1} !== {8'h33, 5'd1}) begin n_fail++;
      $display("FAIL fwft_pop got=%h/%0d exp=33/1", rd1, cnt1); end
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_full_empty_rw();
    test_flush();
    test_fwft();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
